// File: rtl/mips_pkg.sv
// Shared definitions for the five-stage MIPS-subset core: encodings, ALU ops
// and the pipeline-register layouts.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [31:0] NOP_INSTR = 32'h00000000;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_NOR = 3'd4,
        ALU_SLT = 3'd5
    } alu_op_e;

    typedef struct packed {
        logic [31:0] pc4;
        logic [31:0] instr;
    } ifid_t;

    typedef struct packed {
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        branch_eq;
        logic        branch_ne;
        alu_op_e     alu_op;
        logic        alu_src_imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  dest;
        logic [31:0] rs_val;
        logic [31:0] rt_val;
        logic [31:0] imm;
        logic [31:0] pc4;
    } idex_t;

    typedef struct packed {
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic [4:0]  dest;
        logic [31:0] alu_result;
        logic [31:0] store_data;
    } exmem_t;

    typedef struct packed {
        logic        reg_write;
        logic [4:0]  dest;
        logic [31:0] result;
    } memwb_t;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/mips_reg_file.sv
// 32x32 register file: two combinational read ports with write-through
// bypass, one write port, register 0 hard-wired to zero.
module reg_file (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  raddr_a_i,
    input  logic [4:0]  raddr_b_i,
    output logic [31:0] rdata_a_o,
    output logic [31:0] rdata_b_o,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i
);

    logic [31:0] regFile [0:31];

    // Storage: cleared on reset, written at the end of WB.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                regFile[i] <= 32'h0;
            end
        end else if (we_i && (waddr_i != 5'd0)) begin
            regFile[waddr_i] <= wdata_i;
        end
    end

    // Read ports; a read of the register being written returns the new value.
    always_comb begin
        rdata_a_o = regFile[raddr_a_i];
        rdata_b_o = regFile[raddr_b_i];
        if (raddr_a_i == 5'd0) begin
            rdata_a_o = 32'h0;
        end else if (we_i && (waddr_i == raddr_a_i)) begin
            rdata_a_o = wdata_i;
        end else begin
            rdata_a_o = regFile[raddr_a_i];
        end
        if (raddr_b_i == 5'd0) begin
            rdata_b_o = 32'h0;
        end else if (we_i && (waddr_i == raddr_b_i)) begin
            rdata_b_o = wdata_i;
        end else begin
            rdata_b_o = regFile[raddr_b_i];
        end
    end

endmodule

// File: rtl/mips_cpu.sv
// Five-stage pipelined MIPS-subset core with forwarding, load-use stall,
// EX-resolved branches and ID-resolved jumps.
module mips_cpu
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] instructionAddress,
    input  logic [31:0] instruction,
    output logic [31:0] dataAddress,
    output logic [31:0] dataIn,
    output logic        MemRead,
    output logic        MemWrite,
    input  logic [31:0] dataOut
);

    logic [31:0] pc_q, pc_d;
    ifid_t       ifid_q, ifid_d;
    idex_t       idex_q, idex_d;
    exmem_t      exmem_q, exmem_d;
    memwb_t      memwb_q, memwb_d;

    logic [5:0]  id_op_s, id_funct_s;
    logic [4:0]  id_rs_s, id_rt_s, id_rd_s;
    logic [31:0] rf_a_s, rf_b_s, id_jtarget_s;
    idex_t       id_dec_s;
    logic        id_jump_s, id_use_rs_s, id_use_rt_s, rtype_ok_s, stall_s;
    logic [31:0] ex_a_s, ex_b_s, alu_b_s, alu_y_s, ex_target_s;
    logic        ex_taken_s;

    assign id_op_s      = ifid_q.instr[31:26];
    assign id_rs_s      = ifid_q.instr[25:21];
    assign id_rt_s      = ifid_q.instr[20:16];
    assign id_rd_s      = ifid_q.instr[15:11];
    assign id_funct_s   = ifid_q.instr[5:0];
    assign id_jtarget_s = {ifid_q.pc4[31:28], ifid_q.instr[25:0], 2'b00};

    reg_file regFile (
        .clk       (clk),
        .reset     (reset),
        .raddr_a_i (id_rs_s),
        .raddr_b_i (id_rt_s),
        .rdata_a_o (rf_a_s),
        .rdata_b_o (rf_b_s),
        .we_i      (memwb_q.reg_write),
        .waddr_i   (memwb_q.dest),
        .wdata_i   (memwb_q.result)
    );

    // Control decode; unknown opcodes and functs leave every control bit low.
    always_comb begin
        id_dec_s        = '0;
        id_dec_s.alu_op = ALU_ADD;
        id_dec_s.rs     = id_rs_s;
        id_dec_s.rt     = id_rt_s;
        id_dec_s.rs_val = rf_a_s;
        id_dec_s.rt_val = rf_b_s;
        id_dec_s.imm    = sext16(ifid_q.instr[15:0]);
        id_dec_s.pc4    = ifid_q.pc4;
        id_jump_s       = 1'b0;
        id_use_rs_s     = 1'b0;
        id_use_rt_s     = 1'b0;
        rtype_ok_s      = 1'b1;
        case (id_op_s)
            OP_RTYPE: begin
                case (id_funct_s)
                    FN_ADD:  id_dec_s.alu_op = ALU_ADD;
                    FN_SUB:  id_dec_s.alu_op = ALU_SUB;
                    FN_AND:  id_dec_s.alu_op = ALU_AND;
                    FN_OR:   id_dec_s.alu_op = ALU_OR;
                    FN_NOR:  id_dec_s.alu_op = ALU_NOR;
                    FN_SLT:  id_dec_s.alu_op = ALU_SLT;
                    default: rtype_ok_s = 1'b0;
                endcase
                if (rtype_ok_s) begin
                    id_dec_s.reg_write = 1'b1;
                    id_dec_s.dest      = id_rd_s;
                    id_use_rs_s        = 1'b1;
                    id_use_rt_s        = 1'b1;
                end else begin
                    id_dec_s.reg_write = 1'b0;
                end
            end
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_LW: begin
                id_dec_s.reg_write   = 1'b1;
                id_dec_s.dest        = id_rt_s;
                id_dec_s.alu_src_imm = 1'b1;
                id_dec_s.mem_read    = (id_op_s == OP_LW);
                id_use_rs_s          = 1'b1;
                case (id_op_s)
                    OP_SLTI: id_dec_s.alu_op = ALU_SLT;
                    OP_ANDI: begin
                        id_dec_s.alu_op = ALU_AND;
                        id_dec_s.imm    = {16'h0000, ifid_q.instr[15:0]};
                    end
                    OP_ORI: begin
                        id_dec_s.alu_op = ALU_OR;
                        id_dec_s.imm    = {16'h0000, ifid_q.instr[15:0]};
                    end
                    default: id_dec_s.alu_op = ALU_ADD;
                endcase
            end
            OP_SW: begin
                id_dec_s.mem_write   = 1'b1;
                id_dec_s.alu_src_imm = 1'b1;
                id_use_rs_s          = 1'b1;
                id_use_rt_s          = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                id_dec_s.branch_eq = (id_op_s == OP_BEQ);
                id_dec_s.branch_ne = (id_op_s == OP_BNE);
                id_use_rs_s        = 1'b1;
                id_use_rt_s        = 1'b1;
            end
            OP_J:    id_jump_s = 1'b1;
            default: id_jump_s = 1'b0;
        endcase
    end

    assign stall_s = idex_q.mem_read &&
                     ((id_use_rs_s && (idex_q.rt == id_rs_s)) ||
                      (id_use_rt_s && (idex_q.rt == id_rt_s)));

    // EX stage: operand forwarding, ALU, branch resolution, MEM-stage result select.
    always_comb begin
        if (exmem_q.reg_write && (exmem_q.dest != 5'd0) && (exmem_q.dest == idex_q.rs)) begin
            ex_a_s = exmem_q.alu_result;
        end else if (memwb_q.reg_write && (memwb_q.dest != 5'd0) && (memwb_q.dest == idex_q.rs)) begin
            ex_a_s = memwb_q.result;
        end else begin
            ex_a_s = idex_q.rs_val;
        end
        if (exmem_q.reg_write && (exmem_q.dest != 5'd0) && (exmem_q.dest == idex_q.rt)) begin
            ex_b_s = exmem_q.alu_result;
        end else if (memwb_q.reg_write && (memwb_q.dest != 5'd0) && (memwb_q.dest == idex_q.rt)) begin
            ex_b_s = memwb_q.result;
        end else begin
            ex_b_s = idex_q.rt_val;
        end
        alu_b_s = idex_q.alu_src_imm ? idex_q.imm : ex_b_s;
        case (idex_q.alu_op)
            ALU_ADD: alu_y_s = ex_a_s + alu_b_s;
            ALU_SUB: alu_y_s = ex_a_s - alu_b_s;
            ALU_AND: alu_y_s = ex_a_s & alu_b_s;
            ALU_OR:  alu_y_s = ex_a_s | alu_b_s;
            ALU_NOR: alu_y_s = ~(ex_a_s | alu_b_s);
            ALU_SLT: alu_y_s = {31'h0, ($signed(ex_a_s) < $signed(alu_b_s))};
            default: alu_y_s = ex_a_s + alu_b_s;
        endcase
        ex_taken_s  = (idex_q.branch_eq && (ex_a_s == ex_b_s)) ||
                      (idex_q.branch_ne && (ex_a_s != ex_b_s));
        ex_target_s = idex_q.pc4 + {idex_q.imm[29:0], 2'b00};

        exmem_d.reg_write  = idex_q.reg_write;
        exmem_d.mem_read   = idex_q.mem_read;
        exmem_d.mem_write  = idex_q.mem_write;
        exmem_d.dest       = idex_q.dest;
        exmem_d.alu_result = alu_y_s;
        exmem_d.store_data = ex_b_s;

        memwb_d.reg_write = exmem_q.reg_write;
        memwb_d.dest      = exmem_q.dest;
        memwb_d.result    = exmem_q.mem_read ? dataOut : exmem_q.alu_result;
    end

    // Front end: a taken branch beats a stall, which beats a jump.
    always_comb begin
        pc_d         = pc_q + 32'd4;
        ifid_d.pc4   = pc_q + 32'd4;
        ifid_d.instr = instruction;
        idex_d       = id_dec_s;
        if (ex_taken_s) begin
            pc_d   = ex_target_s;
            ifid_d = '{pc4: 32'h0, instr: NOP_INSTR};
            idex_d = '0;
        end else if (stall_s) begin
            pc_d   = pc_q;
            ifid_d = ifid_q;
            idex_d = '0;
        end else if (id_jump_s) begin
            pc_d   = id_jtarget_s;
            ifid_d = '{pc4: 32'h0, instr: NOP_INSTR};
        end else begin
            pc_d = pc_q + 32'd4;
        end
    end

    // Pipeline registers; reset empties every stage.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q    <= 32'h0;
            ifid_q  <= '{pc4: 32'h0, instr: NOP_INSTR};
            idex_q  <= '0;
            exmem_q <= '0;
            memwb_q <= '0;
        end else begin
            pc_q    <= pc_d;
            ifid_q  <= ifid_d;
            idex_q  <= idex_d;
            exmem_q <= exmem_d;
            memwb_q <= memwb_d;
        end
    end

    assign instructionAddress = pc_q;
    assign dataAddress        = {exmem_q.alu_result[31:2], 2'b00};
    assign dataIn             = exmem_q.store_data;
    assign MemRead            = exmem_q.mem_read;
    assign MemWrite           = exmem_q.mem_write;

endmodule

// File: tb/tb_mips_cpu.sv
// Directed bench for mips_cpu: runs small programs from a combinational memory
// model and compares register and bus state with hand-computed values.
module tb_mips_cpu;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] instructionAddress, instruction, dataAddress, dataIn, dataOut;
    logic        MemRead, MemWrite;

    logic [31:0] imem [0:63];
    logic [31:0] dmem [0:63];
    int checks = 0;
    int errors = 0;

    mips_cpu dut (
        .clk                (clk),
        .reset              (reset),
        .instructionAddress (instructionAddress),
        .instruction        (instruction),
        .dataAddress        (dataAddress),
        .dataIn             (dataIn),
        .MemRead            (MemRead),
        .MemWrite           (MemWrite),
        .dataOut            (dataOut)
    );

    always #5 clk = ~clk;

    assign instruction = imem[instructionAddress[7:2]];
    assign dataOut     = dmem[dataAddress[7:2]];

    always @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 64; i++) dmem[i] <= 32'h0;
        end else if (MemWrite) begin
            dmem[dataAddress[7:2]] <= dataIn;
        end
    end

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'h00, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic clear_imem();
        for (int i = 0; i < 64; i++) imem[i] = 32'h0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        int nz;
        clear_imem();
        do_reset();
        checks++; if (instructionAddress !== 32'h0) begin errors++; $display("FAIL rst_pc: got %h want %h", instructionAddress, 32'h0); end
        checks++; if ({MemRead, MemWrite} !== 2'b00) begin errors++; $display("FAIL rst_strobes: got %b want %b", {MemRead, MemWrite}, 2'b00); end
        checks++; if ({dataAddress, dataIn} !== 64'h0) begin errors++; $display("FAIL rst_dbus: got %h want %h", {dataAddress, dataIn}, 64'h0); end
        nz = 0;
        for (int i = 0; i < 32; i++) if (dut.regFile.regFile[i] !== 32'h0) nz++;
        checks++; if (nz !== 0) begin errors++; $display("FAIL rst_regs: got %0d nonzero want 0", nz); end
        @(posedge clk); #1;
        checks++; if (instructionAddress !== 32'h4) begin errors++; $display("FAIL rst_first_fetch: got %h want %h", instructionAddress, 32'h4); end
    endtask

    task automatic test_forwarding();
        clear_imem();
        imem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
        imem[1] = enc_i(6'h08, 5'd1, 5'd2, 16'd3);
        imem[2] = enc_r(5'd1, 5'd2, 5'd3, 6'h20);
        do_reset();
        repeat (4) @(posedge clk);
        #1;
        checks++; if (dut.regFile.regFile[1] !== 32'd0) begin errors++; $display("FAIL fwd_r1_early: got %h want %h", dut.regFile.regFile[1], 32'd0); end
        @(posedge clk); #1;
        checks++; if (dut.regFile.regFile[1] !== 32'd5) begin errors++; $display("FAIL fwd_r1: got %h want %h", dut.regFile.regFile[1], 32'd5); end
        @(posedge clk); #1;
        checks++; if (dut.regFile.regFile[2] !== 32'd8) begin errors++; $display("FAIL fwd_r2: got %h want %h", dut.regFile.regFile[2], 32'd8); end
        @(posedge clk); #1;
        checks++; if (dut.regFile.regFile[3] !== 32'd13) begin errors++; $display("FAIL fwd_r3: got %h want %h", dut.regFile.regFile[3], 32'd13); end
    endtask

    task automatic test_load_use();
        int mw_cnt, mr_cnt, mw_cyc;
        logic [31:0] mw_addr, mw_data;
        mw_cnt = 0; mr_cnt = 0; mw_cyc = 0; mw_addr = 32'hx; mw_data = 32'hx;
        clear_imem();
        imem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
        imem[1] = enc_i(6'h08, 5'd1, 5'd2, 16'd3);
        imem[2] = enc_r(5'd1, 5'd2, 5'd3, 6'h20);
        imem[3] = enc_i(6'h2B, 5'd0, 5'd3, 16'd0);
        imem[4] = enc_i(6'h23, 5'd0, 5'd4, 16'd0);
        imem[5] = enc_r(5'd4, 5'd4, 5'd5, 6'h20);
        do_reset();
        for (int c = 1; c <= 14; c++) begin
            @(posedge clk); #1;
            if (MemWrite) begin mw_cnt++; mw_cyc = c; mw_addr = dataAddress; mw_data = dataIn; end
            if (MemRead) mr_cnt++;
            if (c == 10) begin
                checks++; if (dut.regFile.regFile[5] !== 32'd0) begin errors++; $display("FAIL lu_r5_bubble: got %h want %h", dut.regFile.regFile[5], 32'd0); end
            end
            if (c == 11) begin
                checks++; if (dut.regFile.regFile[5] !== 32'd26) begin errors++; $display("FAIL lu_r5: got %h want %h", dut.regFile.regFile[5], 32'd26); end
            end
        end
        checks++; if (mw_cnt !== 1) begin errors++; $display("FAIL lu_memwrite_cnt: got %0d want 1", mw_cnt); end
        checks++; if (mw_cyc !== 6) begin errors++; $display("FAIL lu_memwrite_cycle: got %0d want 6", mw_cyc); end
        checks++; if (mw_addr !== 32'd0) begin errors++; $display("FAIL lu_sw_addr: got %h want %h", mw_addr, 32'd0); end
        checks++; if (mw_data !== 32'd13) begin errors++; $display("FAIL lu_sw_data: got %h want %h", mw_data, 32'd13); end
        checks++; if (mr_cnt !== 1) begin errors++; $display("FAIL lu_memread_cnt: got %0d want 1", mr_cnt); end
        checks++; if (dut.regFile.regFile[4] !== 32'd13) begin errors++; $display("FAIL lu_r4: got %h want %h", dut.regFile.regFile[4], 32'd13); end
    endtask

    task automatic test_branch();
        clear_imem();
        imem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
        imem[1] = enc_i(6'h04, 5'd1, 5'd1, 16'd2);
        imem[2] = enc_i(6'h08, 5'd0, 5'd6, 16'd1);
        imem[3] = enc_i(6'h08, 5'd6, 5'd6, 16'd2);
        imem[4] = enc_i(6'h05, 5'd1, 5'd1, 16'd1);
        imem[5] = enc_i(6'h08, 5'd0, 5'd10, 16'd9);
        imem[6] = enc_i(6'h08, 5'd0, 5'd11, 16'd4);
        do_reset();
        for (int c = 1; c <= 14; c++) begin
            @(posedge clk); #1;
            if (c == 4) begin
                checks++; if (instructionAddress !== 32'd16) begin errors++; $display("FAIL br_target: got %h want %h", instructionAddress, 32'd16); end
            end
            if (c == 9) begin
                checks++; if (dut.regFile.regFile[10] !== 32'd0) begin errors++; $display("FAIL br_r10_early: got %h want %h", dut.regFile.regFile[10], 32'd0); end
            end
            if (c == 10) begin
                checks++; if (dut.regFile.regFile[10] !== 32'd9) begin errors++; $display("FAIL bne_not_taken: got %h want %h", dut.regFile.regFile[10], 32'd9); end
            end
        end
        checks++; if (dut.regFile.regFile[6] !== 32'd0) begin errors++; $display("FAIL br_flush_r6: got %h want %h", dut.regFile.regFile[6], 32'd0); end
        checks++; if (dut.regFile.regFile[11] !== 32'd4) begin errors++; $display("FAIL br_r11: got %h want %h", dut.regFile.regFile[11], 32'd4); end
    endtask

    task automatic test_jump();
        clear_imem();
        imem[0]  = {6'h02, 26'd10};
        imem[1]  = enc_i(6'h08, 5'd0, 5'd12, 16'd1);
        imem[2]  = enc_i(6'h08, 5'd0, 5'd12, 16'd2);
        imem[10] = enc_i(6'h08, 5'd0, 5'd13, 16'd3);
        do_reset();
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            if (c == 1) begin
                checks++; if (instructionAddress !== 32'd4) begin errors++; $display("FAIL j_slot_fetch: got %h want %h", instructionAddress, 32'd4); end
            end
            if (c == 2) begin
                checks++; if (instructionAddress !== 32'd40) begin errors++; $display("FAIL j_target: got %h want %h", instructionAddress, 32'd40); end
            end
            if (c == 6) begin
                checks++; if (dut.regFile.regFile[13] !== 32'd0) begin errors++; $display("FAIL j_r13_early: got %h want %h", dut.regFile.regFile[13], 32'd0); end
            end
            if (c == 7) begin
                checks++; if (dut.regFile.regFile[13] !== 32'd3) begin errors++; $display("FAIL j_r13: got %h want %h", dut.regFile.regFile[13], 32'd3); end
            end
        end
        checks++; if (dut.regFile.regFile[12] !== 32'd0) begin errors++; $display("FAIL j_flush_r12: got %h want %h", dut.regFile.regFile[12], 32'd0); end
    endtask

    task automatic test_logic();
        logic [31:0] exp [0:31];
        logic [31:0] got;
        clear_imem();
        imem[0]  = enc_i(6'h08, 5'd0, 5'd0, 16'd7);
        imem[1]  = enc_r(5'd0, 5'd0, 5'd21, 6'h20);
        imem[2]  = enc_i(6'h0D, 5'd0, 5'd7, 16'hFFFF);
        imem[3]  = enc_i(6'h0A, 5'd7, 5'd8, 16'hFFFF);
        imem[4]  = enc_r(5'd0, 5'd0, 5'd9, 6'h27);
        imem[5]  = enc_r(5'd0, 5'd7, 5'd14, 6'h22);
        imem[6]  = enc_r(5'd9, 5'd7, 5'd15, 6'h24);
        imem[7]  = enc_r(5'd14, 5'd0, 5'd16, 6'h2A);
        imem[8]  = enc_i(6'h0C, 5'd9, 5'd17, 16'hF0F0);
        imem[9]  = enc_i(6'h0A, 5'd14, 5'd18, 16'd1);
        imem[10] = enc_i(6'h08, 5'd0, 5'd19, 16'hFFFF);
        for (int i = 0; i < 32; i++) exp[i] = 32'h0;
        exp[7]  = 32'h0000FFFF;
        exp[9]  = 32'hFFFFFFFF;
        exp[14] = 32'hFFFF0001;
        exp[15] = 32'h0000FFFF;
        exp[16] = 32'h00000001;
        exp[17] = 32'h0000F0F0;
        exp[18] = 32'h00000001;
        exp[19] = 32'hFFFFFFFF;
        do_reset();
        repeat (18) @(posedge clk);
        #1;
        for (int i = 0; i < 32; i++) begin
            got = dut.regFile.regFile[i];
            checks++; if (got !== exp[i]) begin errors++; $display("FAIL logic_r%0d: got %h want %h", i, got, exp[i]); end
        end
    endtask

    task automatic test_reset_midrun();
        int nz;
        clear_imem();
        imem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
        imem[1] = enc_i(6'h08, 5'd1, 5'd2, 16'd3);
        imem[2] = enc_i(6'h2B, 5'd0, 5'd1, 16'd8);
        imem[3] = enc_i(6'h23, 5'd0, 5'd3, 16'd8);
        do_reset();
        repeat (5) @(posedge clk);
        #1;
        checks++; if (dut.regFile.regFile[1] !== 32'd5) begin errors++; $display("FAIL mid_pre_r1: got %h want %h", dut.regFile.regFile[1], 32'd5); end
        checks++; if ({MemWrite, dataAddress, dataIn} !== {1'b1, 32'd8, 32'd5}) begin errors++; $display("FAIL mid_pre_sw: got %h want %h", {MemWrite, dataAddress, dataIn}, {1'b1, 32'd8, 32'd5}); end
        reset = 1'b0;
        @(posedge clk); #1;
        checks++; if (instructionAddress !== 32'h0) begin errors++; $display("FAIL mid_pc: got %h want %h", instructionAddress, 32'h0); end
        checks++; if ({MemRead, MemWrite} !== 2'b00) begin errors++; $display("FAIL mid_strobes: got %b want %b", {MemRead, MemWrite}, 2'b00); end
        checks++; if ({dataAddress, dataIn} !== 64'h0) begin errors++; $display("FAIL mid_dbus: got %h want %h", {dataAddress, dataIn}, 64'h0); end
        nz = 0;
        for (int i = 0; i < 32; i++) if (dut.regFile.regFile[i] !== 32'h0) nz++;
        checks++; if (nz !== 0) begin errors++; $display("FAIL mid_regs: got %0d nonzero want 0", nz); end
        reset = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        checks++; if ({dut.regFile.regFile[1], dut.regFile.regFile[2]} !== {32'd5, 32'd0}) begin errors++; $display("FAIL mid_restart_r1: got %h want %h", {dut.regFile.regFile[1], dut.regFile.regFile[2]}, {32'd5, 32'd0}); end
        @(posedge clk); #1;
        checks++; if (dut.regFile.regFile[2] !== 32'd8) begin errors++; $display("FAIL mid_restart_r2: got %h want %h", dut.regFile.regFile[2], 32'd8); end
        repeat (2) @(posedge clk);
        #1;
        checks++; if (dut.regFile.regFile[3] !== 32'd5) begin errors++; $display("FAIL mid_restart_lw: got %h want %h", dut.regFile.regFile[3], 32'd5); end
    endtask

    initial begin
        clear_imem();
        test_reset();
        test_forwarding();
        test_load_use();
        test_branch();
        test_jump();
        test_logic();
        test_reset_midrun();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
